// File: rtl/rx_fir_decimator.sv
// 24-tap raised-cosine matched filter with 4x decimation at a selectable sampling phase.
// Emits one saturated symbol sample and a hard bit decision per symbol.
module rx_fir_decimator #(
  parameter int NB_INPUT   = 8,
  parameter int NBF_INPUT  = 7,
  parameter int NB_OUTPUT  = 8,
  parameter int NBF_OUTPUT = 7,
  parameter int NB_COEFF   = 9,
  parameter int NBF_COEFF  = 7
) (
  input  logic                        clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic signed [NB_INPUT-1:0]  i_data,
  input  logic        [1:0]           i_phase,
  output logic signed [NB_OUTPUT-1:0] o_data,
  output logic                        o_valid,
  output logic                        o_bit
);

  // Tap count and decimation factor are tied to the coefficient table below.
  localparam int N_TAPS    = 24;
  localparam int OS_FACTOR = 4;
  localparam int NB_PHASE  = $clog2(OS_FACTOR);
  localparam int NB_PROD   = NB_INPUT + NB_COEFF;
  localparam int NB_ACC    = NB_PROD + 5;
  localparam int LSB       = NBF_INPUT + NBF_COEFF - NBF_OUTPUT;
  localparam int NB_TOP    = NB_ACC - LSB - NB_OUTPUT + 1;

  localparam logic signed [NB_COEFF-1:0] COEFF [N_TAPS] = '{
    9'sd0,   9'sd1,   9'sd2,   9'sd3,   9'sd0,   -9'sd7,
    -9'sd15, -9'sd16, 9'sd0,   9'sd34,  9'sd77,  9'sd114,
    9'sd128, 9'sd114, 9'sd77,  9'sd34,  9'sd0,   -9'sd16,
    -9'sd15, -9'sd7,  9'sd0,   9'sd3,   9'sd2,   9'sd1
  };

  logic signed [NB_INPUT-1:0]  x [N_TAPS];
  logic        [NB_PHASE-1:0]  phase_cnt;
  logic                        strobe_d;
  logic signed [NB_ACC-1:0]    acc;
  logic        [NB_TOP-1:0]    acc_top;
  logic signed [NB_OUTPUT-1:0] out_sat;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      for (int k = 0; k < N_TAPS; k++) x[k] <= '0;
      phase_cnt <= '0;
      strobe_d  <= 1'b0;
    end else begin
      strobe_d <= 1'b0;
      if (i_enable) begin
        x[0] <= i_data;
        for (int k = 1; k < N_TAPS; k++) x[k] <= x[k-1];
        phase_cnt <= phase_cnt + 1'b1;
        strobe_d  <= (phase_cnt == i_phase);
      end
    end
  end

  // Full-precision sum; products are exact in NB_PROD bits, growth absorbed by NB_ACC.
  always_comb begin
    acc = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      acc = acc + NB_ACC'(NB_PROD'(x[k]) * NB_PROD'(COEFF[k]));
    end
  end

  always_comb begin
    acc_top = acc[NB_ACC-1 -: NB_TOP];
    out_sat = acc[LSB +: NB_OUTPUT];
    if (!((&acc_top) || !(|acc_top))) begin
      out_sat = acc[NB_ACC-1] ? {1'b1, {(NB_OUTPUT-1){1'b0}}}
                              : {1'b0, {(NB_OUTPUT-1){1'b1}}};
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      o_data  <= '0;
      o_valid <= 1'b0;
      o_bit   <= 1'b0;
    end else begin
      o_valid <= strobe_d;
      if (strobe_d) begin
        o_data <= out_sat;
        o_bit  <= ~out_sat[NB_OUTPUT-1];
      end
    end
  end

endmodule
